// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipe_ex pipeline and its result collector.
// N and LAT must track the pipe_ex datapath width and latency.
package pipe_pkg;
  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [N-1:0] result_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is always on o_rdata, and o_valid
// is driven from the registered occupancy count.
module sync_fifo_fwft
  import pipe_pkg::*;
#(
  parameter int W = N,
  parameter int D = DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_valid,
  output logic         o_full
);
  localparam int PW = $clog2(D);

  logic [W-1:0] r_mem [D];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_occ;
  logic          w_pop;

  assign o_valid = (r_occ != '0);
  assign o_full  = (r_occ == (PW+1)'(D));
  assign w_pop   = i_rd & o_valid;
  assign o_rdata = r_mem[r_rd_ptr];

  // The caller only writes when there is room or a pop frees a slot this edge;
  // with both on a full FIFO the write reuses the slot being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ <= r_occ + (PW+1)'(i_wr) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/pipe_result_collector.sv
// Collects pipe_ex results: a valid delay line marks which F samples are real,
// accepted ones go into an FWFT FIFO and feed a running sum and result count.
module pipe_result_collector
  import pipe_pkg::*;
#(
  parameter int N     = pipe_pkg::N,
  parameter int LAT   = pipe_pkg::LAT,
  parameter int DEPTH = pipe_pkg::DEPTH,
  parameter int SW    = 16,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [N-1:0]  f_in,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          full,
  output logic [SW-1:0] sum,
  output logic [CW-1:0] count,
  output logic          drop_err,
  output logic          sum_ovf
);
  logic [LAT-1:0] r_dly;
  logic [SW-1:0]  r_sum;
  logic [CW-1:0]  r_count;
  logic           r_drop_err;
  logic           r_sum_ovf;

  logic           w_cap;
  logic           w_pop;
  logic           w_wr;
  logic [SW:0]    w_sum_ext;

  assign w_cap     = r_dly[LAT-1];
  assign w_pop     = out_valid & out_ready;
  assign w_wr      = w_cap & (~full | w_pop);
  assign w_sum_ext = {1'b0, r_sum} + {1'b0, SW'(f_in)};

  sync_fifo_fwft #(.W(N), .D(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (f_in),
    .i_rd    (out_ready),
    .o_rdata (out_data),
    .o_valid (out_valid),
    .o_full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly      <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
      r_sum_ovf  <= 1'b0;
    end else begin
      r_dly <= {r_dly[LAT-2:0], issue_valid};
      if (w_wr) begin
        r_sum <= w_sum_ext[SW-1:0];
        if (w_sum_ext[SW]) r_sum_ovf <= 1'b1;
        if (r_count != '1) r_count <= r_count + 1'b1;
      end
      if (w_cap & ~w_wr) r_drop_err <= 1'b1;
    end
  end

  assign sum      = r_sum;
  assign count    = r_count;
  assign drop_err = r_drop_err;
  assign sum_ovf  = r_sum_ovf;
endmodule

// File: tb/tb_pipe_result_collector.sv
// Scoreboard bench for pipe_result_collector with a behavioural 3-stage pipe_ex.
// Stimulus pushes hand-computed F values; a negedge monitor checks every pop.
module tb_pipe_result_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  f_in;
  logic [9:0]  out_data;
  logic        out_valid, full, drop_err, sum_ovf;
  logic [15:0] sum;
  logic [7:0]  count;

  // second instance with an 8-bit accumulator for the wrap case
  logic        iv8 = 1'b0;
  logic        ord8 = 1'b1;
  logic [9:0]  f8 = '0;
  logic [9:0]  od8;
  logic        ov8, full8, drop8, ovf8;
  logic [7:0]  sum8, cnt8;

  logic [9:0]  a = '0, b = '0, c = '0, d = '0;
  logic [9:0]  f_comb;
  logic [9:0]  p0 = '0, p1 = '0, p2 = '0;

  logic [9:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // stand-in for pipe_ex: F = ((A+B)+(C-D))*D, three register stages
  assign f_comb = ((a + b) + (c - d)) * d;
  always @(posedge clk) begin
    p0 <= f_comb;
    p1 <= p0;
    p2 <= p1;
  end
  assign f_in = p2;

  pipe_result_collector #(.N(10), .LAT(3), .DEPTH(4), .SW(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .f_in(f_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .sum(sum), .count(count), .drop_err(drop_err), .sum_ovf(sum_ovf)
  );

  pipe_result_collector #(.N(10), .LAT(3), .DEPTH(4), .SW(8), .CW(8)) dut8 (
    .clk(clk), .rst(rst), .issue_valid(iv8), .f_in(f8),
    .out_data(od8), .out_valid(ov8), .out_ready(ord8),
    .full(full8), .sum(sum8), .count(cnt8), .drop_err(drop8), .sum_ovf(ovf8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got data %0d, required no output", out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        $display("pop data=%0d expected=%0d", out_data, e);
        chk("pop_data", {22'd0, out_data}, {22'd0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ia, ib, ic, id, input int f_exp, input bit accept);
    a = 10'(ia); b = 10'(ib); c = 10'(ic); d = 10'(id);
    issue_valid = 1'b1;
    if (accept) exp_q.push_back(10'(f_exp));
    $display("issue A=%0d B=%0d C=%0d D=%0d F=%0d accept=%0d", ia, ib, ic, id, f_exp, accept);
    cyc(1);
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sum", sum, 0);
    chk("rst_count", count, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_sum_ovf", sum_ovf, 0);
    rst = 1'b0;
    cyc(1);

    // integration stream
    out_ready = 1'b1;
    issue(10, 12, 6, 3, 75, 1);
    issue(10, 10, 5, 3, 66, 1);
    issue(20, 11, 1, 4, 112, 1);
    issue(15, 10, 8, 2, 62, 1);
    cyc(6);
    chk("t1_sum", sum, 315);
    chk("t1_count", count, 4);
    chk("t1_drop_err", drop_err, 0);
    chk("t1_drained", exp_q.size(), 0);

    // backpressure with drops
    do_reset();
    out_ready = 1'b0;
    issue(10, 12, 6, 3, 75, 1);
    issue(10, 10, 5, 3, 66, 1);
    issue(20, 11, 1, 4, 112, 1);
    issue(15, 10, 8, 2, 62, 1);
    issue(0, 0, 0, 0, 0, 0);
    issue(10, 10, 5, 3, 66, 0);
    cyc(1);
    chk("t2_full_at_4th", full, 1);
    chk("t2_no_drop_yet", drop_err, 0);
    cyc(2);
    chk("t2_drop_err", drop_err, 1);
    chk("t2_count", count, 4);
    chk("t2_sum", sum, 315);
    out_ready = 1'b1;
    cyc(6);
    chk("t2_empty", out_valid, 0);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_drop_sticky", drop_err, 1);

    // full FIFO with a pop in the capture cycle
    do_reset();
    out_ready = 1'b0;
    issue(10, 12, 6, 3, 75, 1);
    issue(10, 10, 5, 3, 66, 1);
    issue(20, 11, 1, 4, 112, 1);
    issue(15, 10, 8, 2, 62, 1);
    issue(10, 10, 30, 1, 49, 1);
    cyc(2);
    chk("t3_full_before", full, 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("t3_full_after", full, 1);
    chk("t3_no_drop", drop_err, 0);
    chk("t3_count", count, 5);
    chk("t3_sum", sum, 364);
    out_ready = 1'b1;
    cyc(6);
    chk("t3_drained", exp_q.size(), 0);

    // idle slots between issues
    do_reset();
    out_ready = 1'b1;
    issue(10, 10, 30, 1, 49, 1);
    a = 10'd7; b = 10'd9; c = 10'd3; d = 10'd5;
    cyc(2);
    issue(30, 1, 2, 4, 116, 1);
    cyc(6);
    chk("t4_count", count, 2);
    chk("t4_sum", sum, 165);
    chk("t4_drained", exp_q.size(), 0);

    // asynchronous reset with 3 queued and 2 in flight
    do_reset();
    out_ready = 1'b0;
    issue(10, 12, 6, 3, 75, 1);
    issue(10, 10, 5, 3, 66, 1);
    issue(20, 11, 1, 4, 112, 1);
    issue(15, 10, 8, 2, 62, 1);
    issue(10, 10, 30, 1, 49, 1);
    @(posedge clk);
    #2;
    chk("t5_pre_count", count, 3);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_count", count, 0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    cyc(4);
    chk("t5_no_ghost_count", count, 0);
    chk("t5_no_ghost_valid", out_valid, 0);
    chk("t5_no_ghost_sum", sum, 0);

    // 8-bit sum wrap
    f8 = 10'd200;
    iv8 = 1'b1;
    cyc(1);
    iv8 = 1'b0;
    cyc(3);
    chk("t6_sum_200", sum8, 200);
    chk("t6_ovf_clear", ovf8, 0);
    f8 = 10'd100;
    iv8 = 1'b1;
    cyc(1);
    iv8 = 1'b0;
    cyc(3);
    chk("t6_sum_wrap", sum8, 44);
    chk("t6_ovf_set", ovf8, 1);
    f8 = 10'd10;
    iv8 = 1'b1;
    cyc(1);
    iv8 = 1'b0;
    cyc(3);
    chk("t6_sum_after", sum8, 54);
    chk("t6_ovf_sticky", ovf8, 1);
    chk("t6_count", cnt8, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_result_collector.md
Name: pipe_result_collector

Overview:
- Downstream consumer of the 3-stage arithmetic pipeline `pipe_ex`, whose output is F = ((A+B)+(C-D))*D.
- Tracks which issued operand sets are in flight, using a valid delay line matched to the pipeline latency.
- Captures each valid F into a small first-word-fall-through (FWFT) FIFO and presents it on a ready/valid output.
- Keeps a running sum and a count of accepted results for the checker/host side.

Parameters:
- N, 10, data width of F (matches pipeline width)
- LAT, 3, edges from operand sample to F valid at the collector input
- DEPTH, 4, FIFO entries; power of two, ≥2
- SW, 16, running-sum width
- CW, 8, result-counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  high in the cycle a valid A,B,C,D set is sampled by the pipeline at the same edge
- f_in  in  N  pipeline output F
- out_data  out  N  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this edge when out_valid=1
- full  out  1  FIFO holds DEPTH entries
- sum  out  SW  modulo-2^SW sum of accepted results
- count  out  CW  number of accepted results, saturating at 2^CW-1
- drop_err  out  1  sticky: a result was discarded because the FIFO was full
- sum_ovf  out  1  sticky: sum wrapped

Behaviour:
- Reset (asynchronous, any time): clears the delay line, FIFO pointers and occupancy, sum, count, drop_err and sum_ovf.
  - Outputs after reset: out_valid=0, full=0, out_data=0, sum=0, count=0, drop_err=0, sum_ovf=0.
  - In-flight results are discarded; reset mid-stream leaves no ghost captures.
- Delay line: LAT-bit shift register fed by issue_valid.
  - cap = delayed bit LAT-1.
  - issue_valid at edge n → f_in captured at edge n+LAT.
- Capture at an edge with cap=1, evaluated in this order:
  - pop = out_valid & out_ready.
  - If !full or pop: write f_in at wr_ptr, advance wr_ptr, sum += f_in, count += 1 (saturating).
  - Else: discard f_in, set drop_err; sum and count are unchanged.
- Simultaneous write and pop:
  - When full: both happen and occupancy stays DEPTH.
  - When empty: the write lands and there is no pop (out_valid was 0).
  - In all other cases occupancy changes by +1 on write only, -1 on pop only, 0 on both.
- FWFT timing: out_data=mem[rd_ptr] combinationally. out_valid=(occupancy≠0), registered via the occupancy counter. A value written at edge k is visible with out_valid=1 after edge k.
- out_ready with out_valid=0: ignored, no pointer movement.
- Pointers wrap modulo DEPTH. Occupancy counter is width log2(DEPTH)+1; full=(occ==DEPTH).
- Sum arithmetic:
  - f_in is zero-extended to SW before adding.
  - Carry-out sets sum_ovf (sticky); sum keeps the low SW bits.
- Count holds at all-ones once reached.
- drop_err and sum_ovf clear only on rst.
- No combinational path from f_in to any output.

Decomposition:
- Shared package `pipe_pkg`:
  - N and LAT defaults, shared with `pipe_ex`.
  - DEPTH and pointer-width constant (clog2).
  - Result word typedef.
- One natural sub-module: `sync_fifo_fwft` (mem, pointers, occupancy, full/empty).
- Delay line, accumulator and sticky flags live in the top.

Test Plan:
- Integration with `pipe_ex`: issue (10,12,6,3), (10,10,5,3), (20,11,1,4), (15,10,8,2) on consecutive cycles, out_ready=1.
  - Expect out_data 75, 66, 112, 62 at cycles n+3..n+6.
  - Expect sum=315, count=4, drop_err=0.
- Backpressure: out_ready=0, issue 6 results (75, 66, 112, 62, 0, 66).
  - Expect full=1 after the 4th capture and drop_err=1.
  - Expect count=4, sum=315; drained order 75, 66, 112, 62.
- Full + simultaneous pop: FIFO full, out_ready=1 in the cycle a 5th capture (value 49) arrives.
  - Expect no drop; occupancy stays 4; 49 appears as the last entry.
- Gap handling: issue_valid pattern 1,0,0,1 with (10,10,30,1) and (30,1,2,4).
  - Expect exactly two captures, 49 then 116; no capture in the idle slots.
- Reset mid-stream: assert rst asynchronously between edges with 2 results in flight and 3 in the FIFO.
  - Expect out_valid=0 and sum=count=0 immediately.
  - Expect no capture at the following LAT edges.
- Sum wrap with SW=8: accept 200 then 100.
  - Expect sum=44 and sum_ovf=1; sum_ovf stays 1 after further adds.
